// File: rtl/seven_seg_scan_decoder.sv
// Recovers hex frames from a multiplexed 7-segment bus; out_valid rises one cycle after the capture completing a frame,
// frames completing while unaccepted are dropped and counted. Define SEG_ACTIVE_LOW_EN for a common-anode (0 = lit) bus.
module seven_seg_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          seg_in,
  input  logic [DIGITS-1:0]   dig_sel,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [4*DIGITS-1:0] out_value,
  output logic [DIGITS-1:0]   out_blank,
  output logic [DIGITS-1:0]   out_err,
  output logic [CNT_W-1:0]    overrun_cnt
);
  localparam int SCW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SCW-1:0] STABLE_MAX = SCW'(STABLE_CYCLES);

  typedef enum logic {COLLECT, PRESENT} state_t;

  logic [6:0] seg_fix;
`ifdef SEG_ACTIVE_LOW_EN
  assign seg_fix = ~seg_in;
`else
  assign seg_fix = seg_in;
`endif

  logic [6:0]          seg_q, seg_prev_q;
  logic [DIGITS-1:0]   sel_q, sel_prev_q;
  logic [SCW-1:0]      stab_q, stab_d;
  logic                sel_ok, same, capture;
  logic [5:0]          dec;
  logic [4*DIGITS-1:0] slot_val_q, slot_val_d, out_val_q, out_val_d;
  logic [DIGITS-1:0]   slot_blank_q, slot_blank_d, slot_err_q, slot_err_d;
  logic [DIGITS-1:0]   out_blank_q, out_blank_d, out_err_q, out_err_d;
  logic [DIGITS-1:0]   got_q, got_d;
  logic [CNT_W-1:0]    ovr_q, ovr_d;
  state_t              state_q, state_d;
  logic                frame_full, handshake, load, got_clr;

  // Returns {err, blank, nibble}
  function automatic logic [5:0] decode(input logic [6:0] p);
    case (p)
      7'b1111110: decode = 6'h00;
      7'b0110000: decode = 6'h01;
      7'b1101101: decode = 6'h02;
      7'b1111001: decode = 6'h03;
      7'b0110011: decode = 6'h04;
      7'b1011011: decode = 6'h05;
      7'b1011111: decode = 6'h06;
      7'b1110000: decode = 6'h07;
      7'b1111111: decode = 6'h08;
      7'b1111011: decode = 6'h09;
      7'b1110111: decode = 6'h0A;
      7'b0011111: decode = 6'h0B;
      7'b1001110: decode = 6'h0C;
      7'b0111101: decode = 6'h0D;
      7'b1001111: decode = 6'h0E;
      7'b1000111: decode = 6'h0F;
      7'b0000000: decode = 6'b01_0000;
      default:    decode = 6'b10_0000;
    endcase
  endfunction

  assign sel_ok = $onehot(sel_q);
  assign same   = (seg_q == seg_prev_q) && (sel_q == sel_prev_q);
  assign dec    = decode(seg_q);

  // stab_q counts identical samples; it parks at STABLE_MAX so a stable pair is captured only once
  always_comb begin
    stab_d  = stab_q;
    capture = 1'b0;
    if (!sel_ok) begin
      stab_d = '0;
    end else if (!same) begin
      stab_d  = SCW'(1);
      capture = (STABLE_MAX == SCW'(1));
    end else if (stab_q != STABLE_MAX) begin
      stab_d  = stab_q + SCW'(1);
      capture = (stab_d == STABLE_MAX);
    end
  end

  always_comb begin
    slot_val_d   = slot_val_q;
    slot_blank_d = slot_blank_q;
    slot_err_d   = slot_err_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (capture && sel_q[i]) begin
        slot_val_d[4*i +: 4] = dec[3:0];
        slot_blank_d[i]      = dec[4];
        slot_err_d[i]        = dec[5];
      end
    end
  end

  assign frame_full = &got_q;
  assign handshake  = (state_q == PRESENT) && out_ready;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    got_clr = 1'b0;
    ovr_d   = ovr_q;
    case (state_q)
      COLLECT: begin
        if (frame_full) begin
          load    = 1'b1;
          got_clr = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (handshake) begin
          if (frame_full) begin
            load    = 1'b1;
            got_clr = 1'b1;
          end else begin
            state_d = COLLECT;
          end
        end else if (frame_full) begin
          got_clr = 1'b1;
          if (ovr_q != '1) ovr_d = ovr_q + CNT_W'(1);
        end
      end
    endcase
    // A capture landing on the clearing edge belongs to the next frame
    got_d       = (got_clr ? '0 : got_q) | (capture ? sel_q : '0);
    out_val_d   = load ? slot_val_q   : out_val_q;
    out_blank_d = load ? slot_blank_q : out_blank_q;
    out_err_d   = load ? slot_err_q   : out_err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q        <= '0;
      seg_prev_q   <= '0;
      sel_q        <= '0;
      sel_prev_q   <= '0;
      stab_q       <= '0;
      slot_val_q   <= '0;
      slot_blank_q <= '0;
      slot_err_q   <= '0;
      got_q        <= '0;
      out_val_q    <= '0;
      out_blank_q  <= '0;
      out_err_q    <= '0;
      ovr_q        <= '0;
      state_q      <= COLLECT;
    end else begin
      seg_q        <= seg_fix;
      seg_prev_q   <= seg_q;
      sel_q        <= dig_sel;
      sel_prev_q   <= sel_q;
      stab_q       <= stab_d;
      slot_val_q   <= slot_val_d;
      slot_blank_q <= slot_blank_d;
      slot_err_q   <= slot_err_d;
      got_q        <= got_d;
      out_val_q    <= out_val_d;
      out_blank_q  <= out_blank_d;
      out_err_q    <= out_err_d;
      ovr_q        <= ovr_d;
      state_q      <= state_d;
    end
  end

  assign out_valid   = (state_q == PRESENT);
  assign out_value   = out_val_q;
  assign out_blank   = out_blank_q;
  assign out_err     = out_err_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Bench for seven_seg_scan_decoder: frame table, hand-written corner sequences, and random scans checked
// against a run-length model of the bus.
module tb_seven_seg_scan_decoder;
  localparam int DIGITS = 4;
  localparam int S      = 4;
  localparam int CNT_W  = 8;
  localparam int NRAND  = 150;

  localparam logic [6:0] PAT [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  localparam logic [3:0] BAD_SEL [6] = '{4'b0000, 4'b0011, 4'b0101, 4'b1100, 4'b1111, 4'b0110};

  typedef struct packed {
    logic [27:0] pats;
    logic [15:0] val;
    logic [3:0]  blank;
    logic [3:0]  err;
  } vec_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [15:0] val;
    logic [3:0]  blank;
    logic [3:0]  err;
  } frame_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [6:0]          seg_in;
  logic [DIGITS-1:0]   dig_sel;
  logic                out_ready;
  logic                out_valid;
  logic [4*DIGITS-1:0] out_value;
  logic [DIGITS-1:0]   out_blank;
  logic [DIGITS-1:0]   out_err;
  logic [CNT_W-1:0]    overrun_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  logic mon_en    = 1'b0;
  frame_t exp_q[$];
  frame_t obs_q[$];
  vec_t   tv [5];

  seven_seg_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(S), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_sel(dig_sel), .out_ready(out_ready),
    .out_valid(out_valid), .out_value(out_value), .out_blank(out_blank), .out_err(out_err),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (mon_en && out_valid) begin
      frame_t f;
      f.cyc   = 32'(cyc);
      f.val   = out_value;
      f.blank = out_blank;
      f.err   = out_err;
      obs_q.push_back(f);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] bus(input logic [6:0] p);
`ifdef SEG_ACTIVE_LOW_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  // Pair is sampled on exactly n rising edges; returns 1 time unit after the last one
  task automatic drive(input logic [6:0] p, input logic [3:0] sel, input int n);
    seg_in  = bus(p);
    dig_sel = sel;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input int d, input logic [6:0] p, input int n);
    drive(p, 4'(1 << d), n);
  endtask

  task automatic check_frame(input string name, input logic [15:0] val, input logic [3:0] blank,
                             input logic [3:0] err);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_value"}, 32'(out_value), 32'(val));
    check({name, "_blank"}, 32'(out_blank), 32'(blank));
    check({name, "_err"},   32'(out_err),   32'(err));
  endtask

  // {err, blank, nibble} from the glyph table
  function automatic logic [5:0] ref_dec(input logic [6:0] p);
    if (p == 7'b0) return 6'b01_0000;
    for (int k = 0; k < 16; k++) if (PAT[k] == p) return {2'b00, 4'(k)};
    return 6'b10_0000;
  endfunction

  initial begin
    logic [6:0] rp [NRAND];
    logic [3:0] rsel [NRAND];
    int         rh [NRAND];
    logic [15:0] mv;
    logic [3:0]  mb, me, mg;
    int          run_start, run_len, t0, nchk;
    frame_t      ef;

    tv[0] = {7'b1111011, 7'b1001110, 7'b0110000, 7'b1111001, 16'h9C13, 4'b0000, 4'b0000};
    tv[1] = {7'b0110011, 7'b1010101, 7'b0000000, 7'b1111110, 16'h4000, 4'b0010, 4'b0100};
    tv[2] = {7'b1000111, 7'b0111101, 7'b0011111, 7'b1110111, 16'hFDBA, 4'b0000, 4'b0000};
    tv[3] = {7'b1110000, 7'b1011111, 7'b1011011, 7'b1101101, 16'h7652, 4'b0000, 4'b0000};
    tv[4] = {7'b0000000, 7'b0000000, 7'b1001111, 7'b1111111, 16'h00E8, 4'b1100, 4'b0000};

    rst_n = 1'b0; seg_in = bus(7'b0); dig_sel = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_value", 32'(out_value), 32'd0);
    check("reset_flags", 32'({out_blank, out_err}), 32'd0);
    check("reset_overrun", 32'(overrun_cnt), 32'd0);
    rst_n = 1'b1;
    drive(7'b0, 4'b0, 1);

    for (int v = 0; v < 5; v++) begin
      for (int d = 0; d < 4; d++) begin
        scan(d, tv[v].pats[7*d +: 7], 6);
        if (d < 3) check("tbl_early_valid", 32'(out_valid), 32'd0);
      end
      check_frame("tbl", tv[v].val, tv[v].blank, tv[v].err);
      drive(7'b0, 4'b0, 1);
      check("tbl_single_pulse", 32'(out_valid), 32'd0);
      drive(7'b0, 4'b0, 1);
    end

    // Digit2 held one cycle short of capture
    scan(0, PAT[1], 6); scan(1, PAT[2], 6); scan(2, PAT[3], 3); scan(3, PAT[4], 6);
    check("glitch_no_frame", 32'(out_valid), 32'd0);
    drive(7'b0, 4'b0, 4);
    check("glitch_still_none", 32'(out_valid), 32'd0);
    scan(2, PAT[5], 4);
    check("glitch_before_latency", 32'(out_valid), 32'd0);
    drive(7'b0, 4'b0, 2);
    check_frame("glitch_recovered", 16'h4521, 4'b0, 4'b0);
    drive(7'b0, 4'b0, 2);

    // Backpressure: second frame dropped while the first is held
    out_ready = 1'b0;
    scan(0, PAT[6], 6); scan(1, PAT[7], 6); scan(2, PAT[8], 6); scan(3, PAT[9], 6);
    check_frame("bp_first", 16'h9876, 4'b0, 4'b0);
    scan(0, PAT[10], 6); scan(1, PAT[11], 6); scan(2, PAT[12], 6); scan(3, PAT[13], 6);
    check_frame("bp_held", 16'h9876, 4'b0, 4'b0);
    check("bp_overrun", 32'(overrun_cnt), 32'd1);
    out_ready = 1'b1;
    drive(7'b0, 4'b0, 1);
    check("bp_handshake", 32'(out_valid), 32'd0);
    check("bp_overrun_kept", 32'(overrun_cnt), 32'd1);

    // Multi-hot and zero-hot selects never capture
    drive(PAT[1], 4'b0011, 10);
    drive(PAT[2], 4'b0000, 10);
    scan(2, PAT[3], 6); scan(3, PAT[4], 6);
    drive(7'b0, 4'b0, 4);
    check("badsel_no_capture", 32'(out_valid), 32'd0);
    scan(0, PAT[14], 6); scan(1, PAT[15], 6);
    check_frame("badsel_frame", 16'h43FE, 4'b0, 4'b0);
    drive(7'b0, 4'b0, 2);

    // Reset mid-frame discards the partial frame
    scan(0, PAT[0], 6); scan(1, PAT[8], 6);
    seg_in = bus(7'b0); dig_sel = '0;
    rst_n = 1'b0;
    #1;
    check("midrst_value", 32'(out_value), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_overrun", 32'(overrun_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    scan(2, PAT[2], 6); scan(3, PAT[3], 6);
    drive(7'b0, 4'b0, 3);
    check("midrst_discard", 32'(out_valid), 32'd0);
    scan(0, PAT[0], 6); scan(1, PAT[8], 6);
    check_frame("midrst_refill", 16'h3280, 4'b0, 4'b0);
    drive(7'b0, 4'b0, 2);

    // Random scan: each run of identical valid pairs lasting >= S samples is one capture at start+S
    for (int i = 0; i < NRAND; i++) begin
      if (i > 0 && $urandom_range(0, 7) == 0) begin
        rp[i] = rp[i-1]; rsel[i] = rsel[i-1];
      end else begin
        int q;
        rsel[i] = ($urandom_range(0, 9) == 0) ? BAD_SEL[$urandom_range(0, 5)]
                                              : 4'(1 << $urandom_range(0, 3));
        q = int'($urandom_range(0, 19));
        rp[i] = (q < 16) ? PAT[q] : (q == 16) ? 7'b0 : 7'($urandom);
      end
      rh[i] = int'($urandom_range(1, 8));
    end

    t0 = cyc + 1;
    run_start = t0; run_len = 0; mg = '0; mv = '0; mb = '0; me = '0;
    for (int i = 0; i < NRAND; i++) begin
      run_len += rh[i];
      if (i == NRAND - 1 || rp[i+1] != rp[i] || rsel[i+1] != rsel[i]) begin
        if ($countones(rsel[i]) == 1 && run_len >= S) begin
          for (int d = 0; d < 4; d++) begin
            if (rsel[i][d]) begin
              logic [5:0] r;
              r = ref_dec(rp[i]);
              mv[4*d +: 4] = r[3:0]; mb[d] = r[4]; me[d] = r[5]; mg[d] = 1'b1;
            end
          end
          if (mg == 4'b1111) begin
            ef.cyc = 32'(run_start + S + 1); ef.val = mv; ef.blank = mb; ef.err = me;
            exp_q.push_back(ef);
            mg = '0;
          end
        end
        run_start += run_len;
        run_len = 0;
      end
    end

    mon_en = 1'b1;
    for (int i = 0; i < NRAND; i++) drive(rp[i], rsel[i], rh[i]);
    drive(7'b0, 4'b0, 12);
    mon_en = 1'b0;

    check("rand_frame_count", 32'(obs_q.size()), 32'(exp_q.size()));
    nchk = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int k = 0; k < nchk; k++) begin
      check("rand_cycle", obs_q[k].cyc, exp_q[k].cyc);
      check("rand_value", 32'(obs_q[k].val), 32'(exp_q[k].val));
      check("rand_flags", 32'({obs_q[k].blank, obs_q[k].err}), 32'({exp_q[k].blank, exp_q[k].err}));
    end
    check("rand_overrun", 32'(overrun_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
